// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : code_lock_pkg
//  Description : Shared types and constants for the sequential code lock.
//                Holds the controller state enum, the digit width and small
//                constant helper functions for width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package code_lock_pkg;

    // Width of one code digit (one hex switch nibble).
    localparam int DIGIT_W    = 4;

    // Width of the digit position counter and the largest entry length
    // that counter supports.
    localparam int IDX_W      = 3;
    localparam int MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        S_ENTRY   = 2'd0,
        S_UNLOCK  = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : code_lock_pkg
`default_nettype wire

// File: rtl/code_lock_ctrl_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect
//  Description : Rising-edge detector. The input is delayed by one register
//                and rise_o is high for the cycle where the input is high
//                and the delayed copy is low. The reset value of the delayed
//                copy is a parameter: resetting it to 1 means a level that is
//                already high when reset releases is not reported as an edge.
//  Ports       : clk_i   - system clock
//                reset_i - synchronous active-high reset
//                sig_i   - level input (already synchronized)
//                rise_o  - one-cycle rising-edge indication
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule : edge_detect
`default_nettype wire

// File: rtl/code_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : code_lock_ctrl
//  Description : Sequential combination-lock controller. One digit is set on
//                digit_i and confirmed with a rising edge of enter_i. After
//                NUM_DIGITS digits the whole sequence is judged: a correct
//                code opens an unlock window, a wrong one pulses error_o, and
//                MAX_FAILS consecutive wrong entries start a lockout period.
//  Ports       : clk_i        - system clock, rising edge
//                reset_i      - synchronous active-high reset
//                enter_i      - enter level (edge-detected internally)
//                cancel_i     - aborts a partially entered sequence
//                digit_i      - current digit value
//                unlocked_o   - high for UNLOCK_CYCLES after a correct entry
//                error_o      - one-cycle pulse on a failed entry
//                locked_out_o - high for LOCKOUT_CYCLES after MAX_FAILS fails
//                digit_idx_o  - digits accepted so far in this entry
//                fail_count_o - consecutive failed entries
//  Revision    : 1.0 - initial release
// ============================================================================
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int                            NUM_DIGITS     = 2,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] CODE           = 8'h09,
    parameter int                            UNLOCK_CYCLES  = 50,
    parameter int                            MAX_FAILS      = 3,
    parameter int                            LOCKOUT_CYCLES = 100
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               enter_i,
    input  logic                               cancel_i,
    input  logic [DIGIT_W-1:0]                 digit_i,
    output logic                               unlocked_o,
    output logic                               error_o,
    output logic                               locked_out_o,
    output logic [IDX_W-1:0]                   digit_idx_o,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count_o
);

    localparam int CNT_W = cnt_width(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES));
    localparam int FC_W  = $clog2(MAX_FAILS + 1);

    localparam logic [CNT_W-1:0] C_UNLOCK_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  C_MAX_FAILS    = FC_W'(MAX_FAILS);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [IDX_W-1:0]    digit_idx_q,  digit_idx_d;
    logic                mismatch_q,   mismatch_d;
    logic [FC_W-1:0]     fail_count_q, fail_count_d;
    logic                unlocked_q,   unlocked_d;
    logic                error_q,      error_d;
    logic                locked_out_q, locked_out_d;

    logic                w_press;
    logic                w_fail_event;
    logic                w_digit_bad;
    logic                w_seq_bad;
    logic                w_last_digit;
    logic [DIGIT_W-1:0]  w_code_digits [MAX_DIGITS];

    // The enter history register resets high so that a key still held
    // while reset releases does not register as a press.
    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_enter_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (enter_i),
        .rise_o  (w_press)
    );

    // Unpack the code into a full-size table so it can be indexed directly
    // by the position counter; positions beyond NUM_DIGITS are never used.
    for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_code_digits
        if (g < NUM_DIGITS) begin : g_used
            assign w_code_digits[g] = CODE[g*DIGIT_W +: DIGIT_W];
        end else begin : g_unused
            assign w_code_digits[g] = '0;
        end
    end

    assign w_digit_bad  = (digit_i != w_code_digits[digit_idx_q]);
    assign w_seq_bad    = mismatch_q | w_digit_bad;
    assign w_last_digit = (digit_idx_q == C_LAST_IDX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_ENTRY;
            cnt_q        <= '0;
            digit_idx_q  <= '0;
            mismatch_q   <= 1'b0;
            fail_count_q <= '0;
            unlocked_q   <= 1'b0;
            error_q      <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_idx_q  <= digit_idx_d;
            mismatch_q   <= mismatch_d;
            fail_count_q <= fail_count_d;
            unlocked_q   <= unlocked_d;
            error_q      <= error_d;
            locked_out_q <= locked_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_idx_d  = digit_idx_q;
        mismatch_d   = mismatch_q;
        fail_count_d = fail_count_q;
        w_fail_event = 1'b0;

        case (state_q)
            S_ENTRY: begin
                if (cancel_i) begin
                    // Cancel wins over a simultaneous press.
                    digit_idx_d = '0;
                    mismatch_d  = 1'b0;
                end else if (w_press) begin
                    if (w_last_digit) begin
                        digit_idx_d = '0;
                        mismatch_d  = 1'b0;
                        if (!w_seq_bad) begin
                            state_d      = S_UNLOCK;
                            cnt_d        = C_UNLOCK_LOAD;
                            fail_count_d = '0;
                        end else if ((int'(fail_count_q) + 1) < MAX_FAILS) begin
                            fail_count_d = fail_count_q + FC_W'(1);
                            w_fail_event = 1'b1;
                        end else begin
                            fail_count_d = C_MAX_FAILS;
                            state_d      = S_LOCKOUT;
                            cnt_d        = C_LOCKOUT_LOAD;
                        end
                    end else begin
                        // A wrong digit is only remembered, so the entry
                        // always runs to full length and never reveals
                        // which position was wrong.
                        digit_idx_d = digit_idx_q + IDX_W'(1);
                        mismatch_d  = w_seq_bad;
                    end
                end
            end

            S_UNLOCK: begin
                if (cnt_q == '0) begin
                    state_d = S_ENTRY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d      = S_ENTRY;
                    fail_count_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d     = S_ENTRY;
                cnt_d       = '0;
                digit_idx_d = '0;
                mismatch_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: computed from the upcoming state so the registered
    // outputs line up with the cycle the state is entered.
    // ------------------------------------------------------------------
    always_comb begin
        unlocked_d   = (state_d == S_UNLOCK);
        locked_out_d = (state_d == S_LOCKOUT);
        error_d      = w_fail_event;
    end

    assign unlocked_o   = unlocked_q;
    assign error_o      = error_q;
    assign locked_out_o = locked_out_q;
    assign digit_idx_o  = digit_idx_q;
    assign fail_count_o = fail_count_q;

endmodule : code_lock_ctrl
`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_lock_ctrl
//  Description : Self-checking bench for code_lock_ctrl. A driver applies one
//                input vector per cycle, advances a behavioural lock model and
//                queues the expected outputs; a monitor pops one expectation
//                per clock edge and compares it with the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_lock_ctrl;

    localparam int         NUM_DIGITS     = 2;
    localparam logic [7:0] CODE           = 8'h09;
    localparam int         UNLOCK_CYCLES  = 4;
    localparam int         MAX_FAILS      = 3;
    localparam int         LOCKOUT_CYCLES = 6;
    localparam int         FC_W           = $clog2(MAX_FAILS + 1);

    typedef struct packed {
        logic            unl;
        logic            err;
        logic            lo;
        logic [2:0]      idx;
        logic [FC_W-1:0] fc;
    } exp_t;

    logic            clk;
    logic            reset_i;
    logic            enter_i;
    logic            cancel_i;
    logic [3:0]      digit_i;
    logic            unlocked_o;
    logic            error_o;
    logic            locked_out_o;
    logic [2:0]      digit_idx_o;
    logic [FC_W-1:0] fail_count_o;

    code_lock_ctrl #(
        .NUM_DIGITS     (NUM_DIGITS),
        .CODE           (CODE),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .enter_i      (enter_i),
        .cancel_i     (cancel_i),
        .digit_i      (digit_i),
        .unlocked_o   (unlocked_o),
        .error_o      (error_o),
        .locked_out_o (locked_out_o),
        .digit_idx_o  (digit_idx_o),
        .fail_count_o (fail_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Behavioural model: the lock is described by the digits typed so far,
    // the failure tally and how many cycles of unlock / lockout remain.
    // ------------------------------------------------------------------
    int   m_code [NUM_DIGITS];
    int   m_entered [$];
    int   m_fails;
    int   m_unlock_left;
    int   m_lock_left;
    bit   m_prev_enter;
    bit   m_err;
    exp_t exp_q [$];

    int n_tests;
    int n_fail;

    function automatic void model_step(input bit r, input bit e, input bit c, input int d);
        bit press;
        bit ok;
        if (r) begin
            m_entered.delete();
            m_fails       = 0;
            m_unlock_left = 0;
            m_lock_left   = 0;
            m_prev_enter  = 1'b1;
            m_err         = 1'b0;
            return;
        end
        m_err        = 1'b0;
        press        = e && !m_prev_enter;
        m_prev_enter = e;
        if (m_unlock_left > 0) begin
            m_unlock_left--;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (c) begin
            m_entered.delete();
        end else if (press) begin
            m_entered.push_back(d);
            if (m_entered.size() == NUM_DIGITS) begin
                ok = 1'b1;
                for (int k = 0; k < NUM_DIGITS; k++)
                    if (m_entered[k] != m_code[k]) ok = 1'b0;
                m_entered.delete();
                if (ok) begin
                    m_unlock_left = UNLOCK_CYCLES;
                    m_fails       = 0;
                end else begin
                    m_fails++;
                    if (m_fails >= MAX_FAILS) m_lock_left = LOCKOUT_CYCLES;
                    else                      m_err       = 1'b1;
                end
            end
        end
    endfunction

    function automatic exp_t model_outputs();
        exp_t x;
        x.unl = (m_unlock_left > 0);
        x.err = m_err;
        x.lo  = (m_lock_left > 0);
        x.idx = 3'(m_entered.size());
        x.fc  = FC_W'(m_fails);
        return x;
    endfunction

    // One clock cycle of stimulus: drive at the falling edge, advance the
    // model for the rising edge that follows and queue what it predicts.
    task automatic cyc(input bit r, input bit e, input bit c, input int d);
        @(negedge clk);
        reset_i  = r;
        enter_i  = e;
        cancel_i = c;
        digit_i  = 4'(d);
        model_step(r, e, c, d);
        exp_q.push_back(model_outputs());
    endtask

    task automatic press(input int d);
        cyc(0, 1, 0, d);
        cyc(0, 0, 0, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, $urandom_range(0, 15));
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("unlocked",   int'(unlocked_o),   int'(x.unl));
                chk("error",      int'(error_o),      int'(x.err));
                chk("locked_out", int'(locked_out_o), int'(x.lo));
                chk("digit_idx",  int'(digit_idx_o),  int'(x.idx));
                chk("fail_count", int'(fail_count_o), int'(x.fc));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : driver
        logic [7:0] code_v;
        bit         r;
        bit         c;
        bit         e;
        int         d;
        int         wait_cycles;

        n_tests  = 0;
        n_fail   = 0;
        reset_i  = 1'b1;
        enter_i  = 1'b1;
        cancel_i = 1'b0;
        digit_i  = 4'd0;
        code_v   = CODE;
        for (int k = 0; k < NUM_DIGITS; k++) m_code[k] = int'((code_v >> (4 * k)) & 8'h0F);
        model_step(1, 1, 0, 0);

        // Reset with enter held high, then release reset while still held.
        cyc(1, 1, 0, 9);
        cyc(1, 1, 0, 9);
        cyc(0, 1, 0, 9);
        cyc(0, 1, 0, 9);
        cyc(0, 0, 0, 9);

        // Correct entry.
        press(9); press(0); idle(6);
        // Wrong first digit, right second digit: single failure.
        press(5); press(0); idle(2);
        // Two more wrong entries: error then lockout; correct code ignored.
        press(1); press(2); idle(1);
        press(9); press(9); idle(1);
        press(9); press(0);
        idle(LOCKOUT_CYCLES + 2);
        // Cancel mid-entry, then a correct entry.
        press(9); cyc(0, 0, 1, 0); press(9); press(0); idle(6);
        // Cancel and press together.
        cyc(0, 1, 1, 9); cyc(0, 0, 0, 9); idle(1);
        // Enter held for 20 cycles counts once.
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 9);
        cyc(0, 0, 0, 9); cyc(0, 0, 1, 0);
        // Reset during the second unlocked cycle.
        press(9); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); idle(3);
        // One failure followed by a correct entry.
        press(3); press(0); press(9); press(0); idle(6);

        // Randomized traffic biased toward the correct digits.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 24) == 0);
            e = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0 && m_entered.size() < NUM_DIGITS)
                d = m_code[m_entered.size()];
            else
                d = int'($urandom_range(0, 15));
            cyc(r, e, c, d);
        end

        // Drain the scoreboard within a bounded number of cycles.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_code_lock_ctrl
`default_nettype wire

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Sequential combination-lock controller for the DE1-SoC switch-code datapath. It replaces the static "switches equal a fixed code" compare with a sequenced entry: the user sets one 4-bit digit on the switches and presses enter, once per digit. After the last digit the controller checks the whole sequence and then drives one of three results: an unlock window, an error pulse, or a lockout period after repeated failures. It sits between the board-level input conditioning (synchronized KEY/SW) and the LEDR/HEX drive logic in `DE1_SoC`.

## Interface
- `NUM_DIGITS`, 2, number of digits per entry (1–8).
- `CODE`, 8'h09, packed code; digit k is `CODE[4k+3:4k]`; digit 0 is entered first. Default: 9, then 0.
- `UNLOCK_CYCLES`, 50, length of the unlocked window in clk cycles (≥1).
- `MAX_FAILS`, 3, consecutive failed entries that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 100, length of lockout in clk cycles (≥1).

- `clk`  input  1  single system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `enter`  input  1  level, active-high, already synchronized (inverted KEY); block edge-detects it.
- `cancel`  input  1  level, active-high; aborts a partial entry.
- `digit`  input  4  current switch digit (SW[3:0]).
- `unlocked`  output  1  high during the unlock window.
- `error`  output  1  one-cycle pulse on a failed, non-lockout entry.
- `locked_out`  output  1  high during lockout.
- `digit_idx`  output  3  digits accepted so far in the current entry.
- `fail_count`  output  $clog2(MAX_FAILS+1)  consecutive failures.

## Operation
- States: `S_ENTRY`, `S_UNLOCK`, `S_LOCKOUT`. Reset and idle state is `S_ENTRY`.
- Press definition: `press = enter & ~enter_q`. `enter_q` is registered every cycle in every state and resets to 1, so an enter held high through reset is not a press.
- `S_ENTRY`:
  - A press samples `digit` and compares it with code digit `digit_idx`. Any mismatch sets a sticky `mismatch` flag. Entry is never aborted early, so the position of a wrong digit is not revealed.
  - On a non-final press, `digit_idx` increments.
  - On the final press (`digit_idx == NUM_DIGITS-1`), `digit_idx` returns to 0 and `mismatch` clears. The result depends on the sequence:
    - All digits matched: go to `S_UNLOCK`; `fail_count` becomes 0.
    - Mismatch and `fail_count+1 < MAX_FAILS`: `fail_count` increments, `error` pulses, stay in `S_ENTRY`.
    - Mismatch and `fail_count+1 == MAX_FAILS`: `fail_count` becomes MAX_FAILS; go to `S_LOCKOUT`.
  - `cancel`: `digit_idx` becomes 0 and `mismatch` clears; `fail_count` is unchanged. If `cancel` and a press occur in the same cycle, `cancel` wins and the press is discarded.
- `S_UNLOCK`:
  - `unlocked` = 1.
  - A down-counter loaded with `UNLOCK_CYCLES-1` returns the block to `S_ENTRY` when it reaches 0.
  - Presses and `cancel` are ignored.
- `S_LOCKOUT`:
  - `locked_out` = 1.
  - The counter is loaded with `LOCKOUT_CYCLES-1`. On exit, `fail_count` becomes 0 and the block returns to `S_ENTRY`.
  - Presses and `cancel` are ignored.
- Width rules:
  - One shared down-counter, width `$clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES))`, minimum 1 bit.
  - `fail_count` never exceeds MAX_FAILS.

## Timing
- Reset values: `unlocked`, `error`, `locked_out`, `digit_idx`, `fail_count`, `mismatch` and the counter are all 0. State is `S_ENTRY`; `enter_q` is 1.
- Reset takes precedence over everything. Asserted mid-unlock or mid-lockout, it forces all outputs to 0 on the next edge.
- All outputs are registered.
- Final press sampled at edge t:
  - `unlocked` is high from t+1 for exactly UNLOCK_CYCLES cycles, or
  - `error` is high for cycle t+1 only, or
  - `locked_out` is high for exactly LOCKOUT_CYCLES cycles starting at t+1.
- The first press accepted after unlock or lockout can occur on the first cycle back in `S_ENTRY`.
- `digit` is sampled only on the press cycle; it may change freely at other times.

## Structure
- Package `code_lock_pkg` holds:
  - the `state_t` enum (`S_ENTRY`, `S_UNLOCK`, `S_LOCKOUT`);
  - the `DIGIT_W = 4` constant.
- Sub-module `edge_detect` (registered rising-edge detector, reset value parameterized, set to 1 here). It is reused later for KEY handling in `DE1_SoC`.
- `DE1_SoC` instantiates `code_lock_ctrl` with `reset = ~KEY[0]`, `enter = ~KEY[3]` (after a 2-flop synchronizer), `cancel = ~KEY[2]`, `digit = SW[3:0]`.

## Test plan
Bench parameters: NUM_DIGITS=2, CODE=8'h09, UNLOCK_CYCLES=4, MAX_FAILS=3, LOCKOUT_CYCLES=6.
1. Press with digit=9, then press with digit=0 → `unlocked` high exactly 4 cycles starting one cycle after the 2nd press; `digit_idx` 1 after the 1st press, then 0; `fail_count` stays 0.
2. Press with digit=5, then press with digit=0 → after the 1st press `digit_idx`=1 and no error; after the 2nd press `error` is a single-cycle pulse, `fail_count`=1, `unlocked` stays 0.
3. Three wrong entries → `error` pulses after the 1st and 2nd entries; after the 3rd, `locked_out` high 6 cycles and `error` stays 0. A correct sequence pressed during lockout is ignored. On exit `fail_count`=0.
4. Press 9, then cancel, then press 9 and press 0 → unlock. Cancel and press asserted in the same cycle → `digit_idx` stays 0.
5. `enter` held high for 20 cycles → `digit_idx` advances by 1 only. `enter` high across reset release → no press counted. Reset asserted in the 2nd unlocked cycle → `unlocked`=0 next cycle, state `S_ENTRY`.
6. One failed entry (`fail_count`=1), then a correct entry → unlock and `fail_count`=0.
